// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the coefficient-RAM port arbiter.
// Optional build macro used by the top level: RAM_RAW_BYPASS_EN.
package ram_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

  // Registered read-response tag: which requester owns the data arriving next cycle.
  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } rsp_tag_t;

  // Round-robin successor of idx among n requesters.
  function automatic req_idx_t next_idx(input req_idx_t idx, input int unsigned n);
    return (32'(idx) + 32'd1 >= n) ? '0 : idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side bus of the coefficient-RAM port arbiter.
// slave: the arbiter's view; master: the clients' and RAM's view.
interface ram_port_arbiter_if #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int NUM_REQ   = 2
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [NUM_REQ-1:0]           wr_valid;
  logic [NUM_REQ-1:0]           wr_ready;
  logic [NUM_REQ*AW-1:0]        wr_addr;
  logic [NUM_REQ*MEM_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]           rd_valid;
  logic [NUM_REQ-1:0]           rd_ready;
  logic [NUM_REQ*AW-1:0]        rd_addr;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [MEM_WIDTH-1:0]         rsp_data;
  logic                         ram_en_a;
  logic                         ram_write_en_a;
  logic [AW-1:0]                ram_addr_a;
  logic [MEM_WIDTH-1:0]         ram_data_in_a;
  logic                         ram_en_b;
  logic [AW-1:0]                ram_addr_b;
  logic [MEM_WIDTH-1:0]         ram_data_out_b;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_data_out_b,
    output wr_ready, rd_ready, rsp_valid, rsp_data,
           ram_en_a, ram_write_en_a, ram_addr_a, ram_data_in_a,
           ram_en_b, ram_addr_b
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_data_out_b,
    input  wr_ready, rd_ready, rsp_valid, rsp_data,
           ram_en_a, ram_write_en_a, ram_addr_a, ram_data_in_a,
           ram_en_b, ram_addr_b
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter owning its priority pointer. Search starts at the
// pointer and wraps; after a transfer the pointer moves past the winner.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output req_idx_t           grant_idx
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  req_idx_t    ptr;
  int unsigned cand;
  logic        found;

  // First requesting index at or after ptr (modulo NUM_REQ) wins; nothing while in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[IW'(cand)]) begin
        grant[IW'(cand)] = 1'b1;
        grant_idx        = req_idx_t'(cand);
        found            = 1'b1;
      end
    end
    if (!rst_n) grant = '0;
  end

  // Pointer moves just past the winner on a transfer, otherwise holds.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_idx(grant_idx, NUM_REQ);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a simple dual-port coefficient RAM (A write-only, B read-only)
// between NUM_REQ requesters with independent round-robin arbitration per
// port, and tags each read response with its requester.
// Build macro RAM_RAW_BYPASS_EN: same-cycle write/read to one address
// returns the new write data instead of the RAM's old (read-first) data.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int NUM_REQ   = 2
) (
  input logic                clock,
  input logic                rst_n,
  ram_port_arbiter_if.slave  bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [NUM_REQ-1:0]   wr_grant;
  logic [NUM_REQ-1:0]   rd_grant;
  req_idx_t             wr_gidx;
  req_idx_t             rd_gidx;
  logic                 wr_xfer;
  logic                 rd_xfer;
  logic [AW-1:0]        wr_addr_sel;
  logic [MEM_WIDTH-1:0] wr_data_sel;
  logic [AW-1:0]        rd_addr_sel;
  rsp_tag_t             rsp_tag_q;
  logic [NUM_REQ-1:0]   rsp_valid_c;

  assign wr_xfer = |(bus.wr_valid & wr_grant);
  assign rd_xfer = |(bus.rd_valid & rd_grant);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clock     (clock),
    .rst_n     (rst_n),
    .req       (bus.wr_valid),
    .advance   (wr_xfer),
    .grant     (wr_grant),
    .grant_idx (wr_gidx)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clock     (clock),
    .rst_n     (rst_n),
    .req       (bus.rd_valid),
    .advance   (rd_xfer),
    .grant     (rd_grant),
    .grant_idx (rd_gidx)
  );

  // Select the granted requester's address/data slices for each RAM port.
  always_comb begin
    wr_addr_sel = '0;
    wr_data_sel = '0;
    rd_addr_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_gidx == req_idx_t'(i)) begin
        wr_addr_sel = bus.wr_addr[i*AW +: AW];
        wr_data_sel = bus.wr_data[i*MEM_WIDTH +: MEM_WIDTH];
      end
      if (rd_gidx == req_idx_t'(i)) begin
        rd_addr_sel = bus.rd_addr[i*AW +: AW];
      end
    end
  end

  assign bus.wr_ready       = wr_grant;
  assign bus.rd_ready       = rd_grant;
  assign bus.ram_en_a       = wr_xfer;
  assign bus.ram_write_en_a = wr_xfer;
  assign bus.ram_addr_a     = wr_addr_sel;
  assign bus.ram_data_in_a  = wr_data_sel;
  assign bus.ram_en_b       = rd_xfer;
  assign bus.ram_addr_b     = rd_addr_sel;

  // Remember which requester owns the RAM data arriving on the next cycle.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rsp_tag_q <= '0;
    end else begin
      rsp_tag_q.valid <= rd_xfer;
      rsp_tag_q.idx   <= rd_gidx;
    end
  end

  // Decode the tag to a one-hot response strobe; a response in flight when
  // reset arrives is suppressed immediately rather than a cycle later.
  always_comb begin
    rsp_valid_c = '0;
    if (rsp_tag_q.valid && rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (rsp_tag_q.idx == req_idx_t'(i)) rsp_valid_c[i] = 1'b1;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_c;

`ifdef RAM_RAW_BYPASS_EN
  logic                 raw_hit_q;
  logic [MEM_WIDTH-1:0] byp_data_q;

  // Flag a same-cycle write/read to one address and keep the written word.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      raw_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      raw_hit_q <= wr_xfer && rd_xfer && (wr_addr_sel == rd_addr_sel);
      if (wr_xfer) byp_data_q <= wr_data_sel;
    end
  end

  assign bus.rsp_data = !rsp_tag_q.valid ? '0 :
                        raw_hit_q        ? byp_data_q : bus.ram_data_out_b;
`else
  assign bus.rsp_data = bus.ram_data_out_b;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with NUM_REQ=2 and a read-first
// 1-cycle-latency RAM model attached to the RAM-side signals.
module tb_ram_port_arbiter;

  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int N  = 2;
  localparam int AW = 10;

`ifdef RAM_RAW_BYPASS_EN
  localparam logic [W-1:0] COLL_EXP = 32'h0000_000B;
`else
  localparam logic [W-1:0] COLL_EXP = 32'h0000_000A;
`endif

  logic        clock = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  int unsigned wr_count = 0;
  logic [W-1:0] mem [0:D-1];

  ram_port_arbiter_if #(.MEM_WIDTH(W), .MEM_DEPTH(D), .NUM_REQ(N)) bus ();

  ram_port_arbiter #(.MEM_WIDTH(W), .MEM_DEPTH(D), .NUM_REQ(N)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // RAM model: read-first, registered output.
  always @(posedge clock) begin
    if (bus.ram_en_a && bus.ram_write_en_a) begin
      mem[bus.ram_addr_a] <= bus.ram_data_in_a;
      wr_count <= wr_count + 1;
    end
    if (bus.ram_en_b) bus.ram_data_out_b <= mem[bus.ram_addr_b];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.wr_valid = '0;
    bus.rd_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] st;
    rst_n        = 1'b0;
    bus.wr_valid = 2'b11;
    bus.rd_valid = 2'b11;
    bus.wr_addr  = {10'd11, 10'd10};
    bus.wr_data  = {32'h0000_1111, 32'h0000_1010};
    bus.rd_addr  = {10'd11, 10'd10};
    for (int c = 0; c < 3; c++) begin
      step();
      settle();
      st = {bus.wr_ready, bus.rd_ready, bus.ram_en_a, bus.ram_write_en_a, bus.ram_en_b, bus.rsp_valid};
      checks++;
      if (st !== 9'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", c, st, 9'b0);
      end
    end
    step();
    rst_n = 1'b1;
    settle();
    st = {bus.wr_ready, bus.rd_ready, bus.ram_en_a, bus.ram_write_en_a, bus.ram_en_b, bus.rsp_valid};
    checks++;
    if (st !== 9'b01_01_1_1_1_00) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected %b", st, 9'b01_01_1_1_1_00);
    end
    checks++;
    if ({bus.ram_addr_a, bus.ram_addr_b} !== {10'd10, 10'd10}) begin
      errors++;
      $display("FAIL reset_first_addr: got %0d/%0d expected 10/10", bus.ram_addr_a, bus.ram_addr_b);
    end
`ifdef RAM_RAW_BYPASS_EN
    checks++;
    if (bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp_data: got %h expected %h", bus.rsp_data, 32'h0);
    end
`endif
    step();
    bus.wr_valid = '0;
    bus.rd_valid = '0;
    settle();
    st = {bus.wr_ready, bus.rd_ready, bus.ram_en_a, bus.ram_write_en_a, bus.ram_en_b, bus.rsp_valid};
    checks++;
    if (st !== 9'b00_00_0_0_0_01) begin
      errors++;
      $display("FAIL reset_first_rsp: got %b expected %b", st, 9'b00_00_0_0_0_01);
    end
  endtask

  task automatic test_fairness();
    logic [1:0]    exp_rdy;
    logic [AW-1:0] exp_addr;
    int unsigned   c0;
    do_reset();
    bus.wr_valid = 2'b11;
    bus.wr_addr  = {10'd21, 10'd20};
    bus.wr_data  = {32'h0000_0021, 32'h0000_0020};
    c0 = wr_count;
    for (int k = 0; k < 6; k++) begin
      settle();
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 10'd20 : 10'd21;
      checks++;
      if ({bus.wr_ready, bus.ram_addr_a, bus.ram_write_en_a} !== {exp_rdy, exp_addr, 1'b1}) begin
        errors++;
        $display("FAIL fair_cycle[%0d]: got rdy=%b addr=%0d we=%b expected rdy=%b addr=%0d we=1",
                 k, bus.wr_ready, bus.ram_addr_a, bus.ram_write_en_a, exp_rdy, exp_addr);
      end
      step();
    end
    checks++;
    if (wr_count - c0 !== 6) begin
      errors++;
      $display("FAIL fair_write_count: got %0d expected 6", wr_count - c0);
    end
    bus.wr_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if ({bus.wr_ready, bus.ram_addr_a} !== {2'b10, 10'd21}) begin
        errors++;
        $display("FAIL sole_requester[%0d]: got rdy=%b addr=%0d expected rdy=10 addr=21",
                 k, bus.wr_ready, bus.ram_addr_a);
      end
      step();
    end
    bus.wr_valid = '0;
  endtask

  task automatic test_read_tag();
    do_reset();
    bus.wr_valid = 2'b01;
    bus.wr_addr  = {10'd0, 10'd5};
    bus.wr_data  = {32'h0, 32'hDEAD_BEEF};
    step();
    bus.wr_addr  = {10'd0, 10'd6};
    bus.wr_data  = {32'h0, 32'h1234_5678};
    step();
    bus.wr_valid = '0;
    bus.rd_valid = 2'b10;
    bus.rd_addr  = {10'd5, 10'd0};
    settle();
    checks++;
    if ({bus.rd_ready, bus.ram_addr_b} !== {2'b10, 10'd5}) begin
      errors++;
      $display("FAIL tag_grant1: got rdy=%b addr=%0d expected rdy=10 addr=5", bus.rd_ready, bus.ram_addr_b);
    end
    step();
    bus.rd_valid = 2'b01;
    bus.rd_addr  = {10'd0, 10'd6};
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rd_ready} !== {2'b10, 32'hDEAD_BEEF, 2'b01}) begin
      errors++;
      $display("FAIL tag_rsp1: got v=%b d=%h rdy=%b expected v=10 d=deadbeef rdy=01",
               bus.rsp_valid, bus.rsp_data, bus.rd_ready);
    end
    step();
    bus.rd_valid = '0;
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, 32'h1234_5678}) begin
      errors++;
      $display("FAIL tag_rsp0: got v=%b d=%h expected v=01 d=12345678", bus.rsp_valid, bus.rsp_data);
    end
    step();
    settle();
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL tag_rsp_single: got %b expected 00", bus.rsp_valid);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.wr_valid = 2'b01;
    bus.wr_addr  = {10'd0, 10'd3};
    bus.wr_data  = {32'h0, 32'h0000_000A};
    step();
    bus.wr_data  = {32'h0, 32'h0000_000B};
    bus.rd_valid = 2'b10;
    bus.rd_addr  = {10'd3, 10'd0};
    settle();
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 4'b01_10) begin
      errors++;
      $display("FAIL coll_grants: got wr=%b rd=%b expected wr=01 rd=10", bus.wr_ready, bus.rd_ready);
    end
    step();
    bus.wr_valid = '0;
    bus.rd_valid = 2'b01;
    bus.rd_addr  = {10'd3, 10'd3};
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rd_ready} !== {2'b10, COLL_EXP, 2'b01}) begin
      errors++;
      $display("FAIL coll_same_cycle: got v=%b d=%h rdy=%b expected v=10 d=%h rdy=01",
               bus.rsp_valid, bus.rsp_data, bus.rd_ready, COLL_EXP);
    end
    step();
    bus.rd_valid = '0;
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, 32'h0000_000B}) begin
      errors++;
      $display("FAIL coll_followup: got v=%b d=%h expected v=01 d=0000000b", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned c0;
    do_reset();
    bus.rd_valid = 2'b01;
    bus.rd_addr  = {10'd6, 10'd5};
    settle();
    checks++;
    if (bus.rd_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_grant: got %b expected 01", bus.rd_ready);
    end
    step();
    c0           = wr_count;
    rst_n        = 1'b0;
    bus.rd_valid = '0;
    bus.wr_valid = 2'b01;
    bus.wr_addr  = {10'd0, 10'd7};
    bus.wr_data  = {32'h0, 32'h0000_0077};
    settle();
    checks++;
    if ({bus.rsp_valid, bus.wr_ready, bus.ram_en_a, bus.ram_write_en_a} !== 6'b0) begin
      errors++;
      $display("FAIL mid_in_reset: got v=%b wrdy=%b en_a=%b we=%b expected all 0",
               bus.rsp_valid, bus.wr_ready, bus.ram_en_a, bus.ram_write_en_a);
    end
    step();
    rst_n        = 1'b1;
    bus.wr_valid = '0;
    bus.rd_valid = 2'b11;
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rd_ready} !== 4'b00_01) begin
      errors++;
      $display("FAIL mid_after_reset: got v=%b rdy=%b expected v=00 rdy=01", bus.rsp_valid, bus.rd_ready);
    end
    checks++;
    if (wr_count !== c0) begin
      errors++;
      $display("FAIL mid_no_write: got %0d writes expected 0", wr_count - c0);
    end
    step();
    bus.rd_valid = '0;
    settle();
    checks++;
    if (bus.rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL mid_rsp_resume: got %b expected 01", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c0;
    do_reset();
    c0           = wr_count;
    bus.wr_valid = 2'b11;
    bus.wr_addr  = {10'd31, 10'd30};
    bus.wr_data  = {32'h0000_0031, 32'h0000_0030};
    settle();
    checks++;
    if ({bus.wr_ready, bus.ram_addr_a} !== {2'b01, 10'd30}) begin
      errors++;
      $display("FAIL held_first: got rdy=%b addr=%0d expected rdy=01 addr=30", bus.wr_ready, bus.ram_addr_a);
    end
    step();
    bus.wr_valid = 2'b10;
    settle();
    checks++;
    if ({bus.wr_ready, bus.ram_addr_a, bus.ram_data_in_a} !== {2'b10, 10'd31, 32'h0000_0031}) begin
      errors++;
      $display("FAIL held_second: got rdy=%b addr=%0d data=%h expected rdy=10 addr=31 data=00000031",
               bus.wr_ready, bus.ram_addr_a, bus.ram_data_in_a);
    end
    step();
    bus.wr_valid = '0;
    settle();
    checks++;
    if ({bus.wr_ready, bus.ram_en_a} !== 3'b00_0) begin
      errors++;
      $display("FAIL held_idle: got rdy=%b en_a=%b expected rdy=00 en_a=0", bus.wr_ready, bus.ram_en_a);
    end
    checks++;
    if (wr_count - c0 !== 2) begin
      errors++;
      $display("FAIL held_write_count: got %0d expected 2", wr_count - c0);
    end
    bus.rd_valid = 2'b11;
    bus.rd_addr  = {10'd31, 10'd30};
    step();
    bus.rd_valid = 2'b10;
    settle();
    checks++;
    if ({bus.rd_ready, bus.rsp_valid, bus.rsp_data} !== {2'b10, 2'b01, 32'h0000_0030}) begin
      errors++;
      $display("FAIL b2b_rsp0: got rdy=%b v=%b d=%h expected rdy=10 v=01 d=00000030",
               bus.rd_ready, bus.rsp_valid, bus.rsp_data);
    end
    step();
    bus.rd_valid = '0;
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {2'b10, 32'h0000_0031}) begin
      errors++;
      $display("FAIL b2b_rsp1: got v=%b d=%h expected v=10 d=00000031", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  initial begin
    bus.wr_valid = '0;
    bus.rd_valid = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;
    test_reset();
    test_fairness();
    test_read_tag();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
